// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner and key-event producer.
//   Drives one column low at a time, samples the synchronised rows on the
//   last cycle of each column window, and assembles the lowest pressed code
//   over a full scan. It debounces across whole scans and emits a one-cycle
//   keyPressed strobe for each accepted key.
//
// Optional feature macro: KEY_REPEAT_EN. When it is defined, a held key
// re-strobes keyPressed every REPEAT_SCANS scans.
//
// Parameters:
//   SCAN_DIV        clk cycles per column window (>= 4)
//   DEBOUNCE_SCANS  identical scans required to accept a change (1..15)
//   REPEAT_SCANS    scans between auto-repeat strobes (KEY_REPEAT_EN only)
//
// Ports:
//   clk         system clock
//   rst_n       async active-low reset
//   row_n[3:0]  keypad rows, active-low, asynchronous to clk
//   col_n[3:0]  column drive, active-low, exactly one bit low
//   keyValue    code of last accepted key (row*4 + col)
//   keyPressed  one-cycle strobe on each accepted key
//   keyHeld     high while the accepted key remains down
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] keyValue,
  output logic       keyPressed,
  output logic       keyHeld
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // A "none" key always carries code 0, so packed equality compares keys correctly.
  typedef struct packed {
    logic       vld;
    logic [3:0] code;
  } key_t;

  localparam key_t KEY_NONE = '{vld: 1'b0, code: 4'd0};

  logic [3:0]    row_s1, row_s2;
  logic [PW-1:0] pre;
  logic [1:0]    col_idx;
  key_t          partial;   // best key found in columns already sampled this scan
  key_t          cand;      // debounce candidate
  key_t          acc;       // accepted state
  logic [3:0]    stb_cnt;

  logic tc;
  assign tc = (pre == PW'(SCAN_DIV - 1));

  // Lowest pressed row in the current column. Scanning from row 3 down
  // to row 0 lets row 0 win.
  key_t hit;
  always_comb begin
    hit = KEY_NONE;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2[r]) begin
        hit.vld  = 1'b1;
        hit.code = {2'(r), col_idx};
      end
    end
  end

  // Merge this column's hit into the running scan result, keeping the lowest code.
  key_t merged;
  always_comb begin
    merged = partial;
    if (hit.vld && (!partial.vld || hit.code < partial.code)) merged = hit;
  end

  // Debounce next-state, used only at the scan boundary (col-3 sample).
  logic       boundary;
  logic [3:0] cnt_nx;
  logic       accept;
  assign boundary = tc && (col_idx == 2'd3);
  always_comb begin
    if (merged == cand)
      cnt_nx = (stb_cnt == 4'(DEBOUNCE_SCANS)) ? stb_cnt : stb_cnt + 4'd1;
    else
      cnt_nx = 4'd1;
  end
  assign accept = boundary && (cnt_nx == 4'(DEBOUNCE_SCANS)) && (merged != acc);

  logic rep_tick;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_cnt;

  // Repeat counter advances on scan boundaries while the accepted key is
  // held. Any accept event, including a release, clears the counter.
  assign rep_tick = boundary && !accept && acc.vld && (rep_cnt == RW'(REPEAT_SCANS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      rep_cnt <= '0;
    else if (boundary) begin
      if (accept || !acc.vld || rep_tick) rep_cnt <= '0;
      else                                rep_cnt <= rep_cnt + RW'(1);
    end
  end
`else
  assign rep_tick = 1'b0;
  // The repeat interval has no effect in this build.
  if (REPEAT_SCANS == 0) begin : g_no_repeat
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1     <= '0;
      row_s2     <= '0;
      pre        <= '0;
      col_idx    <= 2'd0;
      col_n      <= 4'b1110;
      partial    <= KEY_NONE;
      cand       <= KEY_NONE;
      acc        <= KEY_NONE;
      stb_cnt    <= 4'd0;
      keyValue   <= 4'd0;
      keyPressed <= 1'b0;
      keyHeld    <= 1'b0;
    end else begin
      row_s1     <= row_n;
      row_s2     <= row_s1;
      keyPressed <= rep_tick;
      if (tc) begin
        pre     <= '0;
        col_idx <= col_idx + 2'd1;
        col_n   <= {col_n[2:0], col_n[3]};
        partial <= boundary ? KEY_NONE : merged;
      end else begin
        pre <= pre + PW'(1);
      end
      if (boundary) begin
        cand    <= merged;
        stb_cnt <= cnt_nx;
      end
      if (accept) begin
        acc     <= merged;
        keyHeld <= merged.vld;
        if (merged.vld) begin
          keyValue   <= merged.code;
          keyPressed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a behavioural
// keypad matrix (SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3).
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  row_n, col_n, key_value;
  logic        key_pressed, key_held;

  int checks = 0, failures = 0, pulses = 0;
  bit watch_held = 1'b0, held_drop = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .REPEAT_SCANS(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .keyValue(key_value), .keyPressed(key_pressed), .keyHeld(key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_pressed) pulses++;
    if (watch_held && !key_held) held_drop = 1'b1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns the negedge index (1-based) at which keyPressed was seen, or -1.
  task automatic wait_strobe(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (key_pressed) begin n = i; break; end
    end
  endtask

  initial begin
    int n, p0;
    logic [3:0] exp_col;
    repeat (3) @(negedge clk);
    chk("rst_col", col_n, 4'hE);
    chk("rst_value", key_value, 0);
    chk("rst_pressed", key_pressed, 0);
    chk("rst_held", key_held, 0);
    rst_n = 1'b1;

    // Column rotation, 4 cycles per column.
    n = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (col_n != 4'hE) begin n = i; break; end
    end
    chk("col_first_change", n >= 0, 1);
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(4'b0001 << ((1 + i / 4) % 4));
      chk("col_rot", col_n, exp_col);
      @(negedge clk);
    end
    repeat (184) @(negedge clk);
    chk("idle_pulses", pulses, 0);
    chk("idle_held", key_held, 0);
    chk("idle_value", key_value, 0);

`ifdef KEY_REPEAT_EN
    keys = 16'h1 << 5;
    wait_strobe(51, n);
    chk("rep_first_found", n > 0, 1);
    chk("rep_first_value", key_value, 5);
    wait_strobe(60, n);
    chk("rep_gap1", n, 48);
    chk("rep_value1", key_value, 5);
    wait_strobe(60, n);
    chk("rep_gap2", n, 48);
    chk("rep_value2", key_value, 5);
`else
    // Single press of code 6 (row 1, col 2).
    p0 = pulses;
    keys = 16'h1 << 6;
    wait_strobe(51, n);
    chk("press6_found", n > 0, 1);
    chk("press6_value", key_value, 6);
    chk("press6_held", key_held, 1);
    repeat (300) @(negedge clk);
    chk("press6_one_pulse", pulses - p0, 1);

    // Release: keyHeld drops, value holds, no strobe.
    p0 = pulses;
    keys = '0;
    n = -1;
    for (int i = 1; i <= 51; i++) begin
      @(negedge clk);
      if (!key_held) begin n = i; break; end
    end
    chk("release_found", n > 0, 1);
    chk("release_value", key_value, 6);
    repeat (40) @(negedge clk);
    chk("release_no_pulse", pulses - p0, 0);

    // One-scan glitch on code 0 is rejected.
    p0 = pulses;
    keys = 16'h1;
    repeat (16) @(negedge clk);
    keys = '0;
    repeat (100) @(negedge clk);
    chk("glitch_no_pulse", pulses - p0, 0);
    chk("glitch_held", key_held, 0);

    // Direct key change 6 -> 15, then 15 -> {1,6}.
    keys = 16'h1 << 6;
    wait_strobe(51, n);
    chk("chg6_value", key_value, 6);
    watch_held = 1'b1;
    keys = 16'h1 << 15;
    wait_strobe(51, n);
    chk("chg15_found", n > 0, 1);
    chk("chg15_value", key_value, 15);
    chk("chg15_held", key_held, 1);
    keys = (16'h1 << 1) | (16'h1 << 6);
    wait_strobe(51, n);
    chk("multi_value", key_value, 1);
    watch_held = 1'b0;
    chk("chg_held_no_drop", held_drop, 0);

    // Async reset mid-scan while a key is held.
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_col", col_n, 4'hE);
    chk("arst_value", key_value, 0);
    chk("arst_pressed", key_pressed, 0);
    chk("arst_held", key_held, 0);
    @(negedge clk);
    @(negedge clk);
    p0 = pulses;
    rst_n = 1'b1;
    wait_strobe(60, n);
    chk("arst_latency", (n >= 32 && n <= 34), 1);
    chk("arst_value_after", key_value, 1);
    chk("arst_held_after", key_held, 1);
    repeat (100) @(negedge clk);
    chk("arst_one_pulse", pulses - p0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives and reads a 4x4 active-low matrix keypad and produces the key-event interface that note instances consume: keyValue[3:0], a one-cycle keyPressed strobe, and a keyHeld level.
- Sits between the board keypad pins and the note/game logic, and is the producer end of that key interface.
- Synchronises the row inputs, scans one column at a time, debounces across whole scans, and emits one event per debounced press.

Parameters:
- SCAN_DIV, 50000: clk cycles each column is driven (0.5 ms at 100 MHz); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required to accept a change; range 1..15.
- REPEAT_SCANS, 64: scans between auto-repeat strobes; used only with KEY_REPEAT_EN.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- row_n, input, 4: keypad rows, active-low, pulled up, asynchronous to clk.
- col_n, output, 4: column drive, active-low, exactly one bit low at a time.
- keyValue, output, 4: code of the last accepted key = row*4 + col.
- keyPressed, output, 1: single-cycle strobe when a new debounced key is accepted.
- keyHeld, output, 1: high while the accepted key remains down.

Behaviour:
- Reset values (async on rst_n low): col_n=4'b1110, keyValue=0, keyPressed=0, keyHeld=0. Prescaler, column index, sync flops, candidate, stable count and repeat count all clear to 0. Candidate and stable states are "none".
- row_n passes through a 2-FF synchroniser before any use.
- Prescaler counts 0..SCAN_DIV-1.
  - At terminal count, sample the synced rows for the current column, then advance the column index (wraps 3 to 0) and rotate col_n low.
  - The sample uses the last cycle of the column window, which gives settling time.
- Scan result is assembled over columns 0..3.
  - Result = lowest code with a row bit low (row 0 first within col 0, then row 1, and so on), else "none".
  - Multiple simultaneous keys: the lowest code wins.
  - The result is finalised at the col-3 sample, which defines the scan boundary.
- Debounce at each scan boundary:
  - If result == candidate: stable count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: candidate = result, count = 1.
- Acceptance: when count == DEBOUNCE_SCANS and candidate != accepted state, accepted = candidate, and then:
  - Candidate is a key: keyValue = code, keyHeld = 1, keyPressed = 1 for exactly the next clk cycle.
  - Candidate is "none": keyHeld = 0, keyValue holds its last value, no strobe.
  - Key A changes directly to key B: accept B, strobe once, keyHeld stays 1.
- Acceptance happens at most once per change. A steady hold produces no further strobes (except under KEY_REPEAT_EN).
- Latency from a clean edge reaching row_n to keyPressed is between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 scan periods, plus 3 cycles.
- A glitch shorter than DEBOUNCE_SCANS scans never produces a strobe.
- Reset mid-scan aborts immediately. After release, scanning restarts at column 0 with no strobe, even if a key is held. The held key is reported only after full debounce.
- DEBOUNCE_SCANS=1 accepts a change on the first scan that sees it.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - While keyHeld=1 and the accepted key is unchanged, a repeat counter counts scan boundaries.
  - Every REPEAT_SCANS scans after acceptance, keyPressed strobes one cycle with keyValue unchanged.
  - The counter clears on any accept or release.
- Undefined: no repeat logic is built, and exactly one strobe occurs per press.

Test Plan:
Use SCAN_DIV=4, DEBOUNCE_SCANS=2 (scan period 16 cycles).
- Release rst_n with no key down -> col_n cycles 1110, 1101, 1011, 0111 every 4 cycles. keyPressed never asserts, keyHeld=0, keyValue=0 for 200 cycles.
- Hold row 1 on col 2 (row_n=4'b1101 whenever col_n=4'b1011) -> exactly one keyPressed pulse within 51 cycles of the hold starting; keyValue=6, keyHeld=1. No further pulses over 300 cycles.
- Release that key -> keyHeld=0 within 51 cycles, keyValue stays 6, no strobe.
- Pulse row 0 on col 0 for one scan only, then release -> no keyPressed, keyHeld stays 0.
- Hold code 6, then switch to row 3 col 3 without a gap -> a second strobe with keyValue=15, and keyHeld stays 1 throughout. Pressing codes 1 and 6 together -> keyValue=1.
- Drive rst_n low mid-scan while a key is held -> outputs go to reset values asynchronously. After release, the first strobe arrives only after 2 full scans.
- With KEY_REPEAT_EN and REPEAT_SCANS=3, hold code 5 -> strobes at acceptance, then every 48 cycles, each with keyValue=5.
